median_frame_sequencer: RTL and testbench

MEDIAN_FRAME_SEQUENCER -- requirements
Module: median_frame_sequencer

---
 rtl/median_pkg.sv | 18 +
 rtl/median_frame_sequencer_if.sv | 41 ++++
 rtl/raster_addr_counter.sv | 54 +++++
 rtl/median_frame_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_median_frame_sequencer.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/median_pkg.sv
// Shared widths, default image geometry and FSM state type for the median frame sequencer.
package median_pkg;

  localparam int unsigned ImgWDefault = 240;
  localparam int unsigned ImgHDefault = 180;
  localparam int unsigned CoordW      = 8;
  localparam int unsigned ThreshW     = 13;
  localparam int unsigned OnesW       = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StGap,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/median_frame_sequencer_if.sv
// Command, pixel-stream, filter-control and status signals of the median frame sequencer.
interface median_frame_sequencer_if;
  import median_pkg::*;

  logic               cmd_start;
  logic               abort;
  logic [ThreshW-1:0] threshold_cfg;
  logic               pix_valid;
  logic               pix_data;
  logic               pix_ready;
  logic               write_mem;
  logic [CoordW-1:0]  x_address;
  logic [CoordW-1:0]  y_address;
  logic               data_in;
  logic               start;
  logic [ThreshW-1:0] threshold;
  logic               wake_up;
  logic               write_median_mem;
  logic               write_median_data;
  logic               full_image_done;
  logic               busy;
  logic               frame_done;
  logic               timeout_err;
  logic               woke_up;
  logic [OnesW-1:0]   ones_count;

  modport slave (
    input  cmd_start, abort, threshold_cfg, pix_valid, pix_data,
    input  wake_up, write_median_mem, write_median_data, full_image_done,
    output pix_ready, write_mem, x_address, y_address, data_in, start, threshold,
    output busy, frame_done, timeout_err, woke_up, ones_count
  );

  modport master (
    output cmd_start, abort, threshold_cfg, pix_valid, pix_data,
    output wake_up, write_median_mem, write_median_data, full_image_done,
    input  pix_ready, write_mem, x_address, y_address, data_in, start, threshold,
    input  busy, frame_done, timeout_err, woke_up, ones_count
  );

endinterface

// File: rtl/raster_addr_counter.sv
// Column-major raster address counter: y is the inner index, x advances when y wraps.
module raster_addr_counter
  import median_pkg::*;
#(
  parameter int unsigned IMG_W = ImgWDefault,
  parameter int unsigned IMG_H = ImgHDefault
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [CoordW-1:0] x_o,
  output logic [CoordW-1:0] y_o,
  output logic              last_o
);

  logic [CoordW-1:0] x_q, x_d;
  logic [CoordW-1:0] y_q, y_d;
  logic              x_last, y_last;

  assign x_last = (x_q == CoordW'(IMG_W - 1));
  assign y_last = (y_q == CoordW'(IMG_H - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (y_last) begin
        y_d = '0;
        x_d = x_last ? '0 : x_q + 1'b1;
      end else begin
        y_d = y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = x_last && y_last;

endmodule

// File: rtl/median_frame_sequencer.sv
// Loads one binary frame into the median filter memory, starts the filter, and collects
// its result statistics and status until the frame finishes, times out or is aborted.
module median_frame_sequencer
  import median_pkg::*;
#(
  parameter int unsigned IMG_W      = ImgWDefault,
  parameter int unsigned IMG_H      = ImgHDefault,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 2 ** 20
) (
  input logic                      clk_i,
  input logic                      reset_i,
  median_frame_sequencer_if.slave  bus_io
);

  state_e             state_q, state_d;
  logic               write_mem_q, write_mem_d;
  logic [CoordW-1:0]  x_out_q, x_out_d;
  logic [CoordW-1:0]  y_out_q, y_out_d;
  logic               data_q, data_d;
  logic               start_q, start_d;
  logic               frame_done_q, frame_done_d;
  logic [ThreshW-1:0] thr_q, thr_d;
  logic [OnesW-1:0]   ones_q, ones_d;
  logic               woke_q, woke_d;
  logic               tmo_q, tmo_d;
  logic [31:0]        gap_q, gap_d;
  logic [31:0]        run_q, run_d;

  logic              pix_ready;
  logic              transfer;
  logic              cnt_clr;
  logic [CoordW-1:0] cnt_x, cnt_y;
  logic              cnt_last;

  // Ready is withheld during an abort so a dropped frame never consumes a pixel.
  assign pix_ready = (state_q == StLoad) && !bus_io.abort;
  assign transfer  = bus_io.pix_valid && pix_ready;
  assign cnt_clr   = (state_q == StIdle) && bus_io.cmd_start && !bus_io.abort;

  raster_addr_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_addr (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .clr_i  (cnt_clr),
    .en_i   (transfer),
    .x_o    (cnt_x),
    .y_o    (cnt_y),
    .last_o (cnt_last)
  );

  always_comb begin
    state_d      = state_q;
    write_mem_d  = 1'b0;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    data_d       = data_q;
    start_d      = start_q;
    frame_done_d = 1'b0;
    thr_d        = thr_q;
    ones_d       = ones_q;
    woke_d       = woke_q;
    tmo_d        = tmo_q;
    gap_d        = gap_q;
    run_d        = run_q;

    if (bus_io.abort) begin
      state_d = StIdle;
      start_d = 1'b0;
    end else begin
      if ((state_q != StIdle) && bus_io.wake_up) begin
        woke_d = 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (bus_io.cmd_start) begin
            thr_d   = bus_io.threshold_cfg;
            ones_d  = '0;
            woke_d  = 1'b0;
            tmo_d   = 1'b0;
            state_d = StLoad;
          end
        end
        StLoad: begin
          if (transfer) begin
            write_mem_d = 1'b1;
            x_out_d     = cnt_x;
            y_out_d     = cnt_y;
            data_d      = bus_io.pix_data;
            if (cnt_last) begin
              gap_d   = '0;
              state_d = StGap;
            end
          end
        end
        // First GAP cycle carries the final write; GAP_CYCLES idle cycles follow it.
        StGap: begin
          if (gap_q == GAP_CYCLES) begin
            run_d   = '0;
            start_d = 1'b1;
            state_d = StRun;
          end else begin
            gap_d = gap_q + 32'd1;
          end
        end
        StRun: begin
          if (bus_io.write_median_mem && bus_io.write_median_data && (ones_q != '1)) begin
            ones_d = ones_q + 1'b1;
          end
          if (bus_io.full_image_done) begin
            start_d      = 1'b0;
            frame_done_d = 1'b1;
            state_d      = StDone;
          end else if (run_q == TIMEOUT - 1) begin
            tmo_d        = 1'b1;
            start_d      = 1'b0;
            frame_done_d = 1'b1;
            state_d      = StDone;
          end else begin
            run_d = run_q + 32'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          start_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      write_mem_q  <= 1'b0;
      x_out_q      <= '0;
      y_out_q      <= '0;
      data_q       <= 1'b0;
      start_q      <= 1'b0;
      frame_done_q <= 1'b0;
      thr_q        <= '0;
      ones_q       <= '0;
      woke_q       <= 1'b0;
      tmo_q        <= 1'b0;
      gap_q        <= '0;
      run_q        <= '0;
    end else begin
      state_q      <= state_d;
      write_mem_q  <= write_mem_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      data_q       <= data_d;
      start_q      <= start_d;
      frame_done_q <= frame_done_d;
      thr_q        <= thr_d;
      ones_q       <= ones_d;
      woke_q       <= woke_d;
      tmo_q        <= tmo_d;
      gap_q        <= gap_d;
      run_q        <= run_d;
    end
  end

  assign bus_io.pix_ready   = pix_ready;
  assign bus_io.write_mem   = write_mem_q;
  assign bus_io.x_address   = x_out_q;
  assign bus_io.y_address   = y_out_q;
  assign bus_io.data_in     = data_q;
  assign bus_io.start       = start_q;
  assign bus_io.threshold   = thr_q;
  assign bus_io.busy        = (state_q != StIdle);
  assign bus_io.frame_done  = frame_done_q;
  assign bus_io.timeout_err = tmo_q;
  assign bus_io.woke_up     = woke_q;
  assign bus_io.ones_count  = ones_q;

endmodule

// File: tb/tb_median_frame_sequencer.sv
// Directed-random bench for median_frame_sequencer on a 4x3 image with a short timeout.
module tb_median_frame_sequencer;
  import median_pkg::*;

  localparam int unsigned W   = 4;
  localparam int unsigned H   = 3;
  localparam int unsigned Gap = 2;
  localparam int unsigned Tmo = 16;
  localparam int unsigned Pix = W * H;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  median_frame_sequencer_if bus ();

  median_frame_sequencer #(
    .IMG_W     (W),
    .IMG_H     (H),
    .GAP_CYCLES(Gap),
    .TIMEOUT   (Tmo)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int first_wr, last_wr, start_rise, tmo_rise;
  int fd_cnt = 0;
  logic start_prev = 1'b0;
  logic tmo_prev   = 1'b0;
  logic [16:0] cap_q[$];
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One clock cycle; observes outputs on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (bus.write_mem) begin
      cap_q.push_back({bus.x_address, bus.y_address, bus.data_in});
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (bus.start && !start_prev) start_rise = cyc;
    start_prev = bus.start;
    if (bus.timeout_err && !tmo_prev) tmo_rise = cyc;
    tmo_prev = bus.timeout_err;
    if (bus.frame_done) fd_cnt++;
  endtask

  task automatic new_frame(input logic [ThreshW-1:0] cfg);
    cap_q.delete();
    exp_q.delete();
    first_wr   = -1;
    last_wr    = -1;
    start_rise = -1;
    tmo_rise   = -1;
    bus.threshold_cfg = cfg;
    bus.cmd_start     = 1'b1;
    step();
    bus.cmd_start = 1'b0;
    check("start_busy", 32'(bus.busy), 1);
    check("start_thr", 32'(bus.threshold), 32'(cfg));
    check("start_ready", 32'(bus.pix_ready), 1);
  endtask

  // Model: pixel n lands at x = n / H, y = n % H.
  task automatic feed(input bit stall, input int count);
    int n = 0;
    int guard = 0;
    while (n < count && guard < 400) begin
      logic v;
      v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_valid = v;
      bus.pix_data  = 1'($urandom_range(0, 1));
      if (v) begin
        exp_q.push_back({8'(n / int'(H)), 8'(n % int'(H)), bus.pix_data});
        n++;
      end
      step();
      guard++;
    end
    bus.pix_valid = 1'b0;
    check("feed_bound", 32'(n), 32'(count));
  endtask

  task automatic compare_writes(input string tag);
    int dups = 0;
    bit seen[int];
    check({tag, "_wr_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
      check({tag, "_wr_seq"}, 32'(cap_q[i]), 32'(exp_q[i]));
    end
    foreach (cap_q[i]) begin
      if (seen.exists(int'(cap_q[i][16:1]))) dups++;
      seen[int'(cap_q[i][16:1])] = 1'b1;
    end
    check({tag, "_no_dup"}, 32'(dups), 0);
  endtask

  task automatic run_to_start();
    int g = 0;
    while (start_rise < 0 && g < 40) begin
      step();
      g++;
    end
    check("start_seen", 32'(start_rise >= 0), 1);
  endtask

  initial begin
    logic [ThreshW-1:0] cfg_a, cfg_b, cfg_c;
    bit   d5[5];
    int   ones_model, nones, fd_before, g;

    bus.cmd_start = 0; bus.abort = 0; bus.threshold_cfg = '0;
    bus.pix_valid = 0; bus.pix_data = 0; bus.wake_up = 0;
    bus.write_median_mem = 0; bus.write_median_data = 0; bus.full_image_done = 0;

    #1;
    check("rst_flags", 32'({bus.start, bus.busy, bus.write_mem, bus.pix_ready, bus.data_in,
                            bus.frame_done, bus.timeout_err, bus.woke_up}), 0);
    check("rst_addr", 32'({bus.x_address, bus.y_address}), 0);
    check("rst_thr_ones", 32'({bus.threshold, bus.ones_count}), 0);
    @(negedge clk);
    reset = 1'b0;

    // Frame 1: continuous valid, then 5 result writes with 3 ones.
    cfg_a = 13'($urandom);
    new_frame(cfg_a);
    feed(1'b0, Pix);
    check("f1_ready_after_last", 32'(bus.pix_ready), 0);
    compare_writes("f1");
    check("f1_consecutive", 32'(last_wr - first_wr), 32'(Pix - 1));
    run_to_start();
    check("f1_gap", 32'(start_rise - last_wr), 32'(Gap + 1));
    nones = 0;
    foreach (d5[i]) d5[i] = 1'b0;
    while (nones < 3) begin
      int k;
      k = $urandom_range(0, 4);
      if (!d5[k]) begin
        d5[k] = 1'b1;
        nones++;
      end
    end
    ones_model = 0;
    for (int i = 0; i < 5; i++) begin
      bus.write_median_mem  = 1'b1;
      bus.write_median_data = d5[i];
      bus.wake_up           = (i == 2);
      if (d5[i]) ones_model++;
      step();
      bus.write_median_mem  = 1'b0;
      bus.write_median_data = 1'($urandom_range(0, 1));
      bus.wake_up           = 1'b0;
      step();
    end
    bus.write_median_data = 1'b0;
    check("f1_start_held", 32'(bus.start), 1);
    bus.full_image_done = 1'b1;
    step();
    bus.full_image_done = 1'b0;
    check("f1_done_pulse", 32'(bus.frame_done), 1);
    check("f1_start_drop", 32'(bus.start), 0);
    check("f1_ones", 32'(bus.ones_count), 32'(ones_model));
    check("f1_woke", 32'(bus.woke_up), 1);
    step();
    check("f1_idle_busy", 32'(bus.busy), 0);
    check("f1_done_once", 32'(fd_cnt), 1);
    check("f1_ones_hold", 32'(bus.ones_count), 32'(ones_model));

    // Frame 2: 50% stalls, stray cmdStart/fullImageDone in LOAD, then timeout.
    cfg_b = 13'($urandom);
    new_frame(cfg_b);
    check("f2_ones_clr", 32'(bus.ones_count), 0);
    check("f2_woke_clr", 32'(bus.woke_up), 0);
    bus.cmd_start       = 1'b1;
    bus.threshold_cfg   = ~cfg_b;
    bus.full_image_done = 1'b1;
    feed(1'b1, Pix);
    bus.cmd_start       = 1'b0;
    bus.full_image_done = 1'b0;
    check("f2_thr_stable", 32'(bus.threshold), 32'(cfg_b));
    compare_writes("f2");
    run_to_start();
    g = 0;
    while (tmo_rise < 0 && g < 40) begin
      step();
      g++;
    end
    check("f2_tmo_seen", 32'(tmo_rise >= 0), 1);
    check("f2_tmo_cycles", 32'(tmo_rise - start_rise), 32'(Tmo));
    check("f2_tmo_done", 32'(bus.frame_done), 1);
    check("f2_tmo_start", 32'(bus.start), 0);
    step();
    check("f2_tmo_idle", 32'(bus.busy), 0);
    check("f2_tmo_hold", 32'(bus.timeout_err), 1);

    // Frame 3: abort after write 7 together with cmdStart, then restart.
    cfg_a = 13'($urandom);
    new_frame(cfg_a);
    check("f3_tmo_clr", 32'(bus.timeout_err), 0);
    feed(1'b1, 7);
    check("f3_partial", 32'(cap_q.size()), 7);
    fd_before = fd_cnt;
    bus.abort = 1'b1; bus.cmd_start = 1'b1; bus.pix_valid = 1'b1;
    step();
    bus.pix_valid = 1'b0; bus.cmd_start = 1'b0;
    check("f3_abort_flags", 32'({bus.busy, bus.write_mem, bus.pix_ready, bus.start,
                                 bus.frame_done}), 0);
    cfg_c = ~cfg_a;
    bus.threshold_cfg = cfg_c; bus.cmd_start = 1'b1;
    step();
    bus.abort = 1'b0; bus.cmd_start = 1'b0;
    check("f3_abort_vs_cmd", 32'(bus.busy), 0);
    check("f3_thr_not_latched", 32'(bus.threshold), 32'(cfg_a));
    check("f3_no_done", 32'(fd_cnt), 32'(fd_before));
    new_frame(cfg_c);
    feed(1'b0, Pix);
    compare_writes("f3");
    run_to_start();
    bus.full_image_done = 1'b1;
    step();
    bus.full_image_done = 1'b0;
    check("f3_done", 32'(bus.frame_done), 1);
    step();

    // Frame 4: asynchronous reset while running.
    new_frame(13'($urandom));
    feed(1'b0, Pix);
    run_to_start();
    bus.wake_up = 1'b1; bus.write_median_mem = 1'b1; bus.write_median_data = 1'b1;
    step();
    bus.wake_up = 1'b0; bus.write_median_mem = 1'b0; bus.write_median_data = 1'b0;
    check("f4_pre_ones", 32'(bus.ones_count), 1);
    check("f4_pre_woke", 32'(bus.woke_up), 1);
    fd_before = fd_cnt;
    #2 reset = 1'b1;
    #1;
    check("f4_rst_flags", 32'({bus.start, bus.busy, bus.write_mem, bus.pix_ready, bus.data_in,
                               bus.frame_done, bus.timeout_err, bus.woke_up}), 0);
    check("f4_rst_addr", 32'({bus.x_address, bus.y_address}), 0);
    check("f4_rst_thr_ones", 32'({bus.threshold, bus.ones_count}), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("f4_no_done", 32'(fd_cnt), 32'(fd_before));
    check("f4_idle", 32'(bus.busy), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
